// File: rtl/vid_wr_pkg.sv
// Shared state, width helpers and per-channel context for the frame write scheduler.
package vid_wr_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_e;

  // Context fields are sized for the widest supported build (ADDR_W <= 32, NUM_BUF <= 16).
  localparam int CTX_ADDR_W = 32;
  localparam int CTX_BUF_W  = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int num_ch);
    return clog2_min1(num_ch);
  endfunction

  function automatic int buf_w(input int num_buf);
    return clog2_min1(num_buf);
  endfunction

  typedef struct packed {
    logic                  active;
    logic [CTX_ADDR_W-1:0] offset;
    logic [CTX_ADDR_W-1:0] words_left;
    logic [CTX_BUF_W-1:0]  wr_buf;
    logic [CTX_BUF_W-1:0]  rd_buf;
    logic                  pending_restart;
  } ch_ctx_t;

endpackage

// File: rtl/multi_ch_frame_wr_sched_rr_arbiter.sv
// Combinational round-robin picker: searches from the channel after last_grant.
module rr_arbiter
  import vid_wr_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_grant_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              any_grant_o
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_o     = '0;
    any_grant_o = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant_i) + i) % NUM_CH;
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o = 1'b1;
        grant_o     = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/multi_ch_frame_wr_sched.sv
// N-channel frame-write scheduler: round-robin burst commands from per-channel FIFOs,
// one burst outstanding, NUM_BUF rotating frame buffers per channel.
module multi_ch_frame_wr_sched
  import vid_wr_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int NUM_BUF = 2,
  parameter  int ADDR_W  = 28,
  parameter  int FILL_W  = 10,
  parameter  int LEN_W   = 8,
  localparam int CH_W    = ch_w(NUM_CH),
  localparam int BUF_W   = buf_w(NUM_BUF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        frame_words,
  input  logic [LEN_W-1:0]         burst_len,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH-1:0]        ch_frame_start,
  input  logic [NUM_CH*FILL_W-1:0] ch_fill,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [LEN_W-1:0]         cmd_len,
  output logic [CH_W-1:0]          cmd_ch,
  input  logic                     burst_done,
  output logic                     busy,
  output logic [NUM_CH*BUF_W-1:0]  ch_wr_buf,
  output logic [NUM_CH*BUF_W-1:0]  ch_rd_buf,
  output logic [NUM_CH-1:0]        ch_frame_done,
  output logic [NUM_CH-1:0]        ch_overflow
);

  localparam int CW = CTX_ADDR_W;

  state_e            state_q, state_d;
  ch_ctx_t           ctx_q [NUM_CH];
  ch_ctx_t           ctx_d [NUM_CH];
  logic [CH_W-1:0]   last_grant_q, last_grant_d, cur_ch_q, cur_ch_d, grant;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic [NUM_CH-1:0] done_q, done_d, ovf_q, ovf_d, elig, fin, in_flight;
  logic [LEN_W-1:0]  blen [NUM_CH];
  logic              any_grant;

  function automatic logic [CTX_BUF_W-1:0] next_buf(input logic [CTX_BUF_W-1:0] b);
    return (b >= CTX_BUF_W'(NUM_BUF - 1)) ? '0 : b + 1'b1;
  endfunction

  always_comb begin
    elig      = '0;
    fin       = '0;
    in_flight = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      blen[c] = (ctx_q[c].words_left < CW'(burst_len)) ? LEN_W'(ctx_q[c].words_left) : burst_len;
      elig[c] = ctx_q[c].active && (ctx_q[c].words_left != '0) &&
                (CW'(ch_fill[c*FILL_W +: FILL_W]) >= CW'(blen[c]));
      in_flight[c] = (state_q != IDLE) && (cur_ch_q == CH_W'(c));
      fin[c]       = (state_q == WAIT) && burst_done && (cur_ch_q == CH_W'(c));
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i       (elig),
    .last_grant_i(last_grant_q),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_len_d    = cmd_len_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (enable && any_grant) begin
        state_d    = CMD;
        cur_ch_d   = grant;
        cmd_addr_d = ch_base[int'(grant)*ADDR_W +: ADDR_W]
                   + ADDR_W'(ADDR_W'(ctx_q[grant].wr_buf) * frame_words)
                   + ADDR_W'(ctx_q[grant].offset);
        cmd_len_d  = blen[grant];
      end
      CMD:  if (cmd_ready) state_d = WAIT;
      WAIT: if (burst_done) begin
        state_d      = IDLE;
        last_grant_d = cur_ch_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done_d = '0;
    ovf_d  = ovf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      ctx_d[c] = ctx_q[c];
      if (fin[c] && ctx_q[c].pending_restart) begin
        // Burst belonged to the abandoned frame: drop its accounting and restart.
        ctx_d[c].offset          = '0;
        ctx_d[c].words_left      = CW'(frame_words);
        ctx_d[c].pending_restart = 1'b0;
      end else if (fin[c] && ctx_q[c].words_left == CW'(cmd_len_q)) begin
        done_d[c]           = 1'b1;
        ctx_d[c].rd_buf     = ctx_q[c].wr_buf;
        ctx_d[c].active     = 1'b0;
        ctx_d[c].offset     = CW'(ADDR_W'(ctx_q[c].offset + CW'(cmd_len_q)));
        ctx_d[c].words_left = '0;
        if (ch_frame_start[c] && frame_words != '0) begin
          ctx_d[c].active     = 1'b1;
          ctx_d[c].wr_buf     = next_buf(ctx_q[c].wr_buf);
          ctx_d[c].offset     = '0;
          ctx_d[c].words_left = CW'(frame_words);
        end
      end else if (fin[c] && !ch_frame_start[c]) begin
        ctx_d[c].offset     = CW'(ADDR_W'(ctx_q[c].offset + CW'(cmd_len_q)));
        ctx_d[c].words_left = ctx_q[c].words_left - CW'(cmd_len_q);
      end else if (ch_frame_start[c]) begin
        if (!ctx_q[c].active) begin
          if (frame_words != '0) begin
            ctx_d[c].active     = 1'b1;
            ctx_d[c].wr_buf     = next_buf(ctx_q[c].rd_buf);
            ctx_d[c].offset     = '0;
            ctx_d[c].words_left = CW'(frame_words);
          end
        end else begin
          ovf_d[c] = 1'b1;
          if (in_flight[c] && !fin[c]) begin
            ctx_d[c].pending_restart = 1'b1;
          end else begin
            ctx_d[c].offset     = '0;
            ctx_d[c].words_left = CW'(frame_words);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= '0;
      cur_ch_q     <= '0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      done_q       <= '0;
      ovf_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) ctx_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_ch_q     <= cur_ch_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      for (int c = 0; c < NUM_CH; c++) ctx_q[c] <= ctx_d[c];
    end
  end

  assign cmd_valid     = (state_q == CMD);
  assign busy          = (state_q != IDLE);
  assign cmd_addr      = cmd_addr_q;
  assign cmd_len       = cmd_len_q;
  assign cmd_ch        = cur_ch_q;
  assign ch_frame_done = done_q;
  assign ch_overflow   = ovf_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_buf
    assign ch_wr_buf[c*BUF_W +: BUF_W] = ctx_q[c].wr_buf[BUF_W-1:0];
    assign ch_rd_buf[c*BUF_W +: BUF_W] = ctx_q[c].rd_buf[BUF_W-1:0];
  end

endmodule

// File: tb/tb_multi_ch_frame_wr_sched.sv
// Directed bench for multi_ch_frame_wr_sched (4 channels, triple buffering).
module tb_multi_ch_frame_wr_sched;

  localparam int NCH = 4;
  localparam int AW  = 28;
  localparam int FW  = 10;
  localparam int LW  = 8;
  localparam int BW  = 2;

  logic              clk = 1'b0;
  logic              rst, enable, cmd_valid, cmd_ready, burst_done, busy;
  logic [AW-1:0]     frame_words, cmd_addr;
  logic [LW-1:0]     burst_len, cmd_len;
  logic [NCH*AW-1:0] ch_base;
  logic [NCH-1:0]    ch_frame_start, ch_frame_done, ch_overflow;
  logic [NCH*FW-1:0] ch_fill;
  logic [1:0]        cmd_ch;
  logic [NCH*BW-1:0] ch_wr_buf, ch_rd_buf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_ch_frame_wr_sched #(
    .NUM_CH(NCH), .NUM_BUF(3), .ADDR_W(AW), .FILL_W(FW), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_words(frame_words),
    .burst_len(burst_len), .ch_base(ch_base), .ch_frame_start(ch_frame_start),
    .ch_fill(ch_fill), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ch(cmd_ch),
    .burst_done(burst_done), .busy(busy), .ch_wr_buf(ch_wr_buf),
    .ch_rd_buf(ch_rd_buf), .ch_frame_done(ch_frame_done), .ch_overflow(ch_overflow)
  );

  typedef struct {
    int         setup;
    int         ch;
    int         rel;
    int         len;
    logic [3:0] done;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [AW-1:0] base(input int c);
    return AW'((c + 1) << 20);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fill(input int c, input int v);
    ch_fill[c*FW +: FW] = FW'(v);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    ch_frame_start = m;
    @(negedge clk);
    ch_frame_start = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0;
    ch_frame_start = '0; ch_fill = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " cmd_valid"}, 32'(cmd_valid), 0);
    chk({tag, " busy"},      32'(busy), 0);
    chk({tag, " cmd_addr"},  32'(cmd_addr), 0);
    chk({tag, " cmd_len"},   32'(cmd_len), 0);
    chk({tag, " cmd_ch"},    32'(cmd_ch), 0);
    chk({tag, " wr_buf"},    32'(ch_wr_buf), 0);
    chk({tag, " rd_buf"},    32'(ch_rd_buf), 0);
    chk({tag, " frame_done"},32'(ch_frame_done), 0);
    chk({tag, " overflow"},  32'(ch_overflow), 0);
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " cmd_valid"}, 32'(cmd_valid), 1);
  endtask

  task automatic expect_cmd(input int ch, input logic [AW-1:0] addr, input int len, input string tag);
    wait_valid(tag);
    chk({tag, " cmd_ch"},   32'(cmd_ch), 32'(ch));
    chk({tag, " cmd_addr"}, 32'(cmd_addr), 32'(addr));
    chk({tag, " cmd_len"},  32'(cmd_len), 32'(len));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic complete(input logic [3:0] done, input logic [7:0] rd, input string tag);
    burst_done = 1'b1;
    @(posedge clk);
    #1;
    burst_done = 1'b0;
    chk({tag, " frame_done"}, 32'(ch_frame_done), 32'(done));
    chk({tag, " rd_buf"},     32'(ch_rd_buf), 32'(rd));
    @(negedge clk);
  endtask

  task automatic do_burst(input int ch, input logic [AW-1:0] addr, input int len,
                          input logic [3:0] done, input logic [7:0] rd, input string tag);
    expect_cmd(ch, addr, len, tag);
    chk({tag, " busy"}, 32'(busy), 1);
    complete(done, rd, tag);
  endtask

  task automatic setup(input int scen);
    do_reset();
    enable    = 1'b1;
    burst_len = 8'd16;
    case (scen)
      1: begin frame_words = 64; set_fill(0, 16); pulse_start(4'b0001); end
      2: begin
        frame_words = 64;
        for (int c = 0; c < NCH; c++) set_fill(c, 64);
        pulse_start(4'b1111);
      end
      default: begin frame_words = 40; set_fill(3, 64); pulse_start(4'b1000); end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a0;
    logic [LW-1:0] l0;
    logic [1:0]    c0;
    logic          stable, seen;
    int            exp_wr [3];

    tbl[0]  = '{1, 0,  64, 16, 4'b0000, 8'h00};
    tbl[1]  = '{0, 0,  80, 16, 4'b0000, 8'h00};
    tbl[2]  = '{0, 0,  96, 16, 4'b0000, 8'h00};
    tbl[3]  = '{0, 0, 112, 16, 4'b0001, 8'h01};
    tbl[4]  = '{2, 1,  64, 16, 4'b0000, 8'h00};
    tbl[5]  = '{0, 2,  64, 16, 4'b0000, 8'h00};
    tbl[6]  = '{0, 3,  64, 16, 4'b0000, 8'h00};
    tbl[7]  = '{0, 0,  64, 16, 4'b0000, 8'h00};
    tbl[8]  = '{0, 1,  80, 16, 4'b0000, 8'h00};
    tbl[9]  = '{3, 3,  40, 16, 4'b0000, 8'h00};
    tbl[10] = '{0, 3,  56, 16, 4'b0000, 8'h00};
    tbl[11] = '{0, 3,  72,  8, 4'b1000, 8'h40};

    frame_words = '0; burst_len = 8'd16;
    for (int c = 0; c < NCH; c++) ch_base[c*AW +: AW] = base(c);
    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].setup != 0) setup(tbl[i].setup);
      do_burst(tbl[i].ch, base(tbl[i].ch) + AW'(tbl[i].rel), tbl[i].len,
               tbl[i].done, tbl[i].rd, $sformatf("vec%0d", i));
    end

    // Restart requested while ch1's burst is in flight.
    do_reset();
    enable = 1'b1; burst_len = 16; frame_words = 64; set_fill(1, 64);
    pulse_start(4'b0010);
    expect_cmd(1, base(1) + 64, 16, "ovf first");
    pulse_start(4'b0010);
    chk("ovf inflight flag", 32'(ch_overflow), 32'h2);
    complete(4'b0000, 8'h00, "ovf discard");
    do_burst(1, base(1) + 64, 16, 4'b0000, 8'h00, "ovf restart");
    pulse_start(4'b0100);
    pulse_start(4'b0100);
    chk("ovf idle flag", 32'(ch_overflow), 32'h6);
    chk("ovf wr_buf", 32'(ch_wr_buf), 32'h14);

    // Three one-burst frames on ch2 rotate through all three buffers.
    do_reset();
    enable = 1'b1; burst_len = 16; frame_words = 16; set_fill(2, 64);
    exp_wr = '{1, 2, 0};
    for (int k = 0; k < 3; k++) begin
      pulse_start(4'b0100);
      chk($sformatf("tri wr_buf%0d", k), 32'(ch_wr_buf[5:4]), 32'(exp_wr[k]));
      do_burst(2, base(2) + AW'(exp_wr[k] * 16), 16, 4'b0100,
               8'(exp_wr[k] << 4), $sformatf("tri%0d", k));
    end

    // Frame start coincides with the completing burst on ch3.
    do_reset();
    enable = 1'b1; burst_len = 16; frame_words = 16; set_fill(3, 64);
    pulse_start(4'b1000);
    expect_cmd(3, base(3) + 16, 16, "same first");
    burst_done = 1'b1; ch_frame_start = 4'b1000;
    @(posedge clk);
    #1;
    burst_done = 1'b0; ch_frame_start = '0;
    chk("same frame_done", 32'(ch_frame_done), 32'h8);
    chk("same rd_buf", 32'(ch_rd_buf), 32'h40);
    chk("same wr_buf", 32'(ch_wr_buf), 32'h80);
    chk("same overflow", 32'(ch_overflow), 0);
    repeat (2) @(negedge clk);
    chk("mid busy", 32'(busy), 1);
    do_reset();
    check_reset_state("mid reset");

    // Held cmd_ready, then enable dropped while the burst is in flight.
    enable = 1'b1; burst_len = 16; frame_words = 64; set_fill(0, 64);
    pulse_start(4'b0001);
    wait_valid("bp");
    a0 = cmd_addr; l0 = cmd_len; c0 = cmd_ch;
    chk("bp addr", 32'(a0), 32'(base(0) + 64));
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_addr !== a0 || cmd_len !== l0 || cmd_ch !== c0) stable = 1'b0;
    end
    chk("bp stable", 32'(stable), 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0; enable = 1'b0;
    complete(4'b0000, 8'h00, "bp done");
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) seen = 1'b1;
    end
    chk("en off no cmd", 32'(seen), 0);
    chk("en off busy", 32'(busy), 0);
    enable = 1'b1;
    do_burst(0, base(0) + 80, 16, 4'b0000, 8'h00, "en resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
